// File: rtl/aes_types.sv
// Shared GF(4) definitions for the composite-field AES S-box datapath.
package aes_types;

    localparam int GF4_W = 2;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULN = 2'b01,
        OP_SQ   = 2'b10,
        OP_SQN  = 2'b11
    } gf4_op_e;

    // Scale constant N = omega (polynomial x)
    localparam logic [GF4_W-1:0] GF4_N = 2'b10;

endpackage

// File: rtl/gf4_mul_core.sv
// Combinational GF(4) multiplier over x^2+x+1, shared with the GF(2^4) stages.
module gf4_mul_core
    import aes_types::*;
(
    input  logic [GF4_W-1:0] a,
    input  logic [GF4_W-1:0] b,
    output logic [GF4_W-1:0] p
);

    logic hi_s;

    // a1*b1 contributes to both bits because x^2 reduces to x+1
    assign hi_s = a[1] & b[1];
    assign p[1] = hi_s ^ (a[1] & b[0]) ^ (a[0] & b[1]);
    assign p[0] = hi_s ^ (a[0] & b[0]);

endmodule

// File: rtl/gf_mul_scl_2.sv
// Registered GF(4) multiply / square unit with optional scaling by N = omega.
module gf_mul_scl_2
    import aes_types::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [GF4_W-1:0] a,
    input  logic [GF4_W-1:0] b,
    output logic             out_valid,
    output logic [GF4_W-1:0] p
);

    // Multiplication by omega: {r1,r0} -> {r1^r0, r1}
    function automatic logic [GF4_W-1:0] gf4_scale(input logic [GF4_W-1:0] r);
        return {r[1] ^ r[0], r[1]};
    endfunction

    // Squaring is linear in GF(4) and doubles as inversion for non-zero inputs
    function automatic logic [GF4_W-1:0] gf4_square(input logic [GF4_W-1:0] r);
        return {r[1], r[1] ^ r[0]};
    endfunction

    logic [GF4_W-1:0] mul_s;
    logic [GF4_W-1:0] sq_s;
    logic [GF4_W-1:0] result_s;
    logic [GF4_W-1:0] p_d;
    logic [GF4_W-1:0] p_q;
    logic             out_valid_d;
    logic             out_valid_q;

    gf4_mul_core u_mul (
        .a (a),
        .b (b),
        .p (mul_s)
    );

    assign sq_s = gf4_square(a);

    // Operation select
    always_comb begin
        result_s = 2'b00;
        case (gf4_op_e'(op))
            OP_MUL:  result_s = mul_s;
            OP_MULN: result_s = gf4_scale(mul_s);
            OP_SQ:   result_s = sq_s;
            OP_SQN:  result_s = gf4_scale(sq_s);
            default: result_s = 2'b00;
        endcase
    end

    // Next state: result is captured only on valid cycles, held otherwise
    always_comb begin
        p_d         = p_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            p_d         = result_s;
            out_valid_d = 1'b1;
        end else begin
            p_d         = p_q;
            out_valid_d = 1'b0;
        end
    end

    // Output and valid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q         <= 2'b00;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign p         = p_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_gf_mul_scl_2.sv
// Directed self-checking bench for gf_mul_scl_2 with hand-computed GF(4) results.
module tb_gf_mul_scl_2;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] op;
    logic [1:0] a;
    logic [1:0] b;
    logic       out_valid;
    logic [1:0] p;

    int n_checks;
    int n_pass;

    gf_mul_scl_2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .p         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    // Drive one cycle of inputs at the falling edge, sample after the next rising edge
    task automatic step(input logic v, input logic [1:0] o, input logic [1:0] va, input logic [1:0] vb);
        @(negedge clk);
        in_valid = v;
        op       = o;
        a        = va;
        b        = vb;
        @(posedge clk);
        #1;
    endtask

    // Hand-written GF(4) multiplication table, row a, column b
    logic [1:0] mul_tab [4][4];
    logic [1:0] pa  [7];
    logic [1:0] pb  [7];
    logic [1:0] exp_mul  [7];
    logic [1:0] exp_muln [7];
    logic [1:0] exp_sq   [4];
    logic [1:0] exp_sqn  [4];

    initial begin
        mul_tab[0] = '{2'd0, 2'd0, 2'd0, 2'd0};
        mul_tab[1] = '{2'd0, 2'd1, 2'd2, 2'd3};
        mul_tab[2] = '{2'd0, 2'd2, 2'd3, 2'd1};
        mul_tab[3] = '{2'd0, 2'd3, 2'd1, 2'd2};
        pa       = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd3, 2'd1, 2'd3};
        pb       = '{2'd0, 2'd2, 2'd2, 2'd3, 2'd2, 2'd1, 2'd3};
        exp_mul  = '{2'd0, 2'd2, 2'd3, 2'd3, 2'd1, 2'd1, 2'd2};
        exp_muln = '{2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
        exp_sq   = '{2'd0, 2'd1, 2'd3, 2'd2};
        exp_sqn  = '{2'd0, 2'd2, 2'd1, 2'd3};

        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        op       = 2'b00;
        a        = 2'b00;
        b        = 2'b00;
        #2;
        check("reset_p", 32'(p), 32'd0);
        check("reset_vld", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            step(1'b1, 2'b00, pa[i], pb[i]);
            check($sformatf("mul_%0d", i), 32'(p), 32'(exp_mul[i]));
            check($sformatf("mul_vld_%0d", i), 32'(out_valid), 32'd1);
        end

        for (int i = 0; i < 7; i++) begin
            step(1'b1, 2'b01, pa[i], pb[i]);
            check($sformatf("muln_%0d", i), 32'(p), 32'(exp_muln[i]));
        end

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'b10, 2'(i), 2'(3 - i));
            check($sformatf("sq_%0d", i), 32'(p), 32'(exp_sq[i]));
        end

        // a * a^-1 must be 1 for every non-zero a
        for (int i = 1; i < 4; i++) begin
            step(1'b1, 2'b00, 2'(i), exp_sq[i]);
            check($sformatf("inv_prod_%0d", i), 32'(p), 32'd1);
        end

        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'b11, 2'(i), 2'(i));
            check($sformatf("sqn_%0d", i), 32'(p), 32'(exp_sqn[i]));
        end

        // Valid gap: p holds across an idle cycle with changed operands
        step(1'b1, 2'b00, 2'd1, 2'd2);
        check("gap_p0", 32'(p), 32'd2);
        check("gap_vld0", 32'(out_valid), 32'd1);
        step(1'b0, 2'b01, 2'd3, 2'd3);
        check("gap_p1", 32'(p), 32'd2);
        check("gap_vld1", 32'(out_valid), 32'd0);
        step(1'b1, 2'b00, 2'd2, 2'd2);
        check("gap_p2", 32'(p), 32'd3);
        check("gap_vld2", 32'(out_valid), 32'd1);

        // Mid-stream asynchronous reset, checked before any further clock edge
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_p", 32'(p), 32'd0);
        check("async_rst_vld", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'b01, 2'd3, 2'd3);
        check("post_rst_p", 32'(p), 32'd3);
        check("post_rst_vld", 32'(out_valid), 32'd1);

        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                step(1'b1, 2'b00, 2'(i), 2'(j));
                check($sformatf("tab_%0d_%0d", i, j), 32'(p), 32'(mul_tab[i][j]));
            end
        end

        step(1'b0, 2'b00, 2'd0, 2'd0);
        check("idle_vld", 32'(out_valid), 32'd0);
        check("idle_hold", 32'(p), 32'(mul_tab[3][3]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
